param_fifo: RTL and testbench

Parametrised synchronous FIFO that replaces the fixed 4-bit input/output FIFOs in the TOP datapath. It adds configurable data width and depth, an occupancy count, programmable almost-full and almost-empty thresholds, sticky overflow and underflow error flags, and a synchronous flush. It sits between the DEMUX write/read-enable fan-out and the MUX output selection, in the same place the current in/out FIFOs occupy.

---
 rtl/param_fifo.sv | 102 ++++++++++
 tb/tb_param_fifo.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO with occupancy count, almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and a synchronous flush.
module param_fifo #(
   parameter int DATA_WIDTH    = 4,
   parameter int DEPTH         = 8,
   parameter int AFULL_THRESH  = DEPTH - 2,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                    inClock,
   input  logic                    inReset,
   input  logic                    inWriteEnable,
   input  logic [DATA_WIDTH-1:0]   inData,
   input  logic                    inReadEnable,
   input  logic                    inClear,
   output logic [DATA_WIDTH-1:0]   outData,
   output logic                    outValid,
   output logic [$clog2(DEPTH):0]  outCount,
   output logic                    outFull,
   output logic                    outEmpty,
   output logic                    outAlmostFull,
   output logic                    outAlmostEmpty,
   output logic                    outOverflow,
   output logic                    outUnderflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wptr;
   logic [AW-1:0]         rptr;
   logic [CW-1:0]         count;
   logic                  isFull;
   logic                  isEmpty;
   logic                  readAccept;
   logic                  writeAccept;
   logic                  writeReject;
   logic                  readReject;

   assign isFull  = (count == CW'(DEPTH));
   assign isEmpty = (count == '0);

   // A flush masks every request; a write into a full FIFO only lands if a
   // read frees a slot in the same cycle, and a write never rescues an empty read.
   assign readAccept  = inReadEnable  && !inClear && !isEmpty;
   assign writeAccept = inWriteEnable && !inClear && (!isFull || readAccept);
   assign writeReject = inWriteEnable && !inClear && !writeAccept;
   assign readReject  = inReadEnable  && !inClear && isEmpty;

   always_ff @(posedge inClock) begin
      if (writeAccept) begin
         mem[wptr] <= inData;
      end
   end

   always_ff @(posedge inClock or negedge inReset) begin
      if (!inReset) begin
         wptr         <= '0;
         rptr         <= '0;
         count        <= '0;
         outData      <= '0;
         outValid     <= 1'b0;
         outOverflow  <= 1'b0;
         outUnderflow <= 1'b0;
      end else if (inClear) begin
         wptr         <= '0;
         rptr         <= '0;
         count        <= '0;
         outValid     <= 1'b0;
         outOverflow  <= 1'b0;
         outUnderflow <= 1'b0;
      end else begin
         outValid <= readAccept;
         if (writeAccept) begin
            wptr <= wptr + 1'b1;
         end
         if (readAccept) begin
            rptr    <= rptr + 1'b1;
            outData <= mem[rptr];
         end
         case ({writeAccept, readAccept})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (writeReject) begin
            outOverflow <= 1'b1;
         end
         if (readReject) begin
            outUnderflow <= 1'b1;
         end
      end
   end

   // Status is decoded from the registered count only, never from this cycle's enables.
   assign outCount       = count;
   assign outFull        = isFull;
   assign outEmpty       = isEmpty;
   assign outAlmostFull  = (count >= CW'(AFULL_THRESH));
   assign outAlmostEmpty = (count <= CW'(AEMPTY_THRESH));

endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo with default parameters (4-bit data, depth 8).
module tb_param_fifo;

   logic       inClock = 1'b0;
   logic       inReset;
   logic       inWriteEnable;
   logic [3:0] inData;
   logic       inReadEnable;
   logic       inClear;
   logic [3:0] outData;
   logic       outValid;
   logic [3:0] outCount;
   logic       outFull;
   logic       outEmpty;
   logic       outAlmostFull;
   logic       outAlmostEmpty;
   logic       outOverflow;
   logic       outUnderflow;

   int total = 0;
   int bad   = 0;

   param_fifo dut (
      .inClock(inClock), .inReset(inReset), .inWriteEnable(inWriteEnable),
      .inData(inData), .inReadEnable(inReadEnable), .inClear(inClear),
      .outData(outData), .outValid(outValid), .outCount(outCount),
      .outFull(outFull), .outEmpty(outEmpty), .outAlmostFull(outAlmostFull),
      .outAlmostEmpty(outAlmostEmpty), .outOverflow(outOverflow),
      .outUnderflow(outUnderflow)
   );

   always #5 inClock = ~inClock;

   // Apply one cycle of requests, then sample 1 time unit after the rising edge.
   task automatic drive(input logic we, input logic [3:0] d, input logic re, input logic clr);
      inWriteEnable = we;
      inData        = d;
      inReadEnable  = re;
      inClear       = clr;
      @(posedge inClock);
      #1;
      inWriteEnable = 1'b0;
      inReadEnable  = 1'b0;
      inClear       = 1'b0;
   endtask

   task automatic test_reset;
      inReset = 1'b0;
      inWriteEnable = 1'b0; inReadEnable = 1'b0; inClear = 1'b0; inData = 4'h0;
      #2;
      total++;
      if ({outCount, outEmpty, outAlmostEmpty, outFull, outAlmostFull, outValid, outOverflow, outUnderflow, outData} !== {4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0}) begin
         bad++;
         $display("FAIL reset_state: count=%0d empty=%b aempty=%b full=%b afull=%b valid=%b ovf=%b unf=%b data=%h, required 0 1 1 0 0 0 0 0 0",
                  outCount, outEmpty, outAlmostEmpty, outFull, outAlmostFull, outValid, outOverflow, outUnderflow, outData);
      end
      @(posedge inClock);
      #3 inReset = 1'b1;
      @(posedge inClock);
      #1;
   endtask

   task automatic test_basic;
      logic [3:0] vals [3] = '{4'h1, 4'h4, 4'h9};
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, vals[i], 1'b0, 1'b0);
         total++;
         if (outCount !== 4'(i + 1)) begin
            bad++;
            $display("FAIL basic_wr_count[%0d]: got %0d, required %0d", i, outCount, i + 1);
         end
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 4'h0, 1'b1, 1'b0);
         total++;
         if (outValid !== 1'b1 || outData !== vals[i] || outCount !== 4'(2 - i)) begin
            bad++;
            $display("FAIL basic_rd[%0d]: valid=%b data=%h count=%0d, required 1 %h %0d", i, outValid, outData, outCount, vals[i], 2 - i);
         end
      end
      drive(1'b0, 4'h0, 1'b0, 1'b0);
      total++;
      if (outValid !== 1'b0 || outEmpty !== 1'b1) begin
         bad++;
         $display("FAIL basic_idle: valid=%b empty=%b, required 0 1", outValid, outEmpty);
      end
   endtask

   task automatic test_fill_overflow;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 4'(i), 1'b0, 1'b0);
         total++;
         if (outCount !== 4'(i + 1) || outAlmostFull !== (i + 1 >= 6) || outFull !== (i == 7) || outAlmostEmpty !== (i + 1 <= 2)) begin
            bad++;
            $display("FAIL fill[%0d]: count=%0d afull=%b full=%b aempty=%b, required %0d %b %b %b",
                     i, outCount, outAlmostFull, outFull, outAlmostEmpty, i + 1, (i + 1 >= 6), (i == 7), (i + 1 <= 2));
         end
      end
      drive(1'b1, 4'hF, 1'b0, 1'b0);
      total++;
      if (outOverflow !== 1'b1 || outCount !== 4'd8 || outFull !== 1'b1) begin
         bad++;
         $display("FAIL overflow: ovf=%b count=%0d full=%b, required 1 8 1", outOverflow, outCount, outFull);
      end
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 4'h0, 1'b1, 1'b0);
         total++;
         if (outValid !== 1'b1 || outData !== 4'(i)) begin
            bad++;
            $display("FAIL drain[%0d]: valid=%b data=%h, required 1 %h", i, outValid, outData, 4'(i));
         end
      end
      total++;
      if (outEmpty !== 1'b1 || outOverflow !== 1'b1) begin
         bad++;
         $display("FAIL drain_end: empty=%b ovf=%b, required 1 1", outEmpty, outOverflow);
      end
      drive(1'b0, 4'h0, 1'b0, 1'b1);
   endtask

   task automatic test_underflow_write;
      drive(1'b1, 4'hA, 1'b1, 1'b0);
      total++;
      if (outUnderflow !== 1'b1 || outValid !== 1'b0 || outCount !== 4'd1 || outData !== 4'h7) begin
         bad++;
         $display("FAIL underflow_wr: unf=%b valid=%b count=%0d data=%h, required 1 0 1 7", outUnderflow, outValid, outCount, outData);
      end
      drive(1'b0, 4'h0, 1'b1, 1'b0);
      total++;
      if (outValid !== 1'b1 || outData !== 4'hA || outCount !== 4'd0) begin
         bad++;
         $display("FAIL underflow_rd: valid=%b data=%h count=%0d, required 1 a 0", outValid, outData, outCount);
      end
      drive(1'b0, 4'h0, 1'b0, 1'b1);
   endtask

   task automatic test_full_rw;
      for (int i = 0; i < 8; i++) drive(1'b1, 4'(i), 1'b0, 1'b0);
      drive(1'b1, 4'hC, 1'b1, 1'b0);
      total++;
      if (outCount !== 4'd8 || outFull !== 1'b1 || outValid !== 1'b1 || outData !== 4'h0 || outOverflow !== 1'b0) begin
         bad++;
         $display("FAIL full_rw: count=%0d full=%b valid=%b data=%h ovf=%b, required 8 1 1 0 0", outCount, outFull, outValid, outData, outOverflow);
      end
      for (int i = 1; i <= 8; i++) begin
         drive(1'b0, 4'h0, 1'b1, 1'b0);
         total++;
         if (outData !== ((i == 8) ? 4'hC : 4'(i))) begin
            bad++;
            $display("FAIL full_rw_drain[%0d]: data=%h, required %h", i, outData, (i == 8) ? 4'hC : 4'(i));
         end
      end
      total++;
      if (outCount !== 4'd0 || outEmpty !== 1'b1) begin
         bad++;
         $display("FAIL full_rw_end: count=%0d empty=%b, required 0 1", outCount, outEmpty);
      end
   endtask

   task automatic test_wrap;
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 4'(i + 3), 1'b0, 1'b0);
         drive(1'b0, 4'h0, 1'b1, 1'b0);
         total++;
         if (outValid !== 1'b1 || outData !== 4'(i + 3)) begin
            bad++;
            $display("FAIL wrap[%0d]: valid=%b data=%h, required 1 %h", i, outValid, outData, 4'(i + 3));
         end
      end
      total++;
      if (outOverflow !== 1'b0 || outUnderflow !== 1'b0 || outCount !== 4'd0) begin
         bad++;
         $display("FAIL wrap_flags: ovf=%b unf=%b count=%0d, required 0 0 0", outOverflow, outUnderflow, outCount);
      end
   endtask

   task automatic test_clear;
      for (int i = 0; i < 8; i++) drive(1'b1, 4'(i), 1'b0, 1'b0);
      drive(1'b1, 4'hF, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b0, 4'h0, 1'b1, 1'b0);
      total++;
      if (outCount !== 4'd5 || outOverflow !== 1'b1 || outData !== 4'h2) begin
         bad++;
         $display("FAIL clear_pre: count=%0d ovf=%b data=%h, required 5 1 2", outCount, outOverflow, outData);
      end
      drive(1'b1, 4'hB, 1'b0, 1'b1);
      total++;
      if (outCount !== 4'd0 || outEmpty !== 1'b1 || outOverflow !== 1'b0 || outUnderflow !== 1'b0 || outValid !== 1'b0 || outData !== 4'h2) begin
         bad++;
         $display("FAIL clear: count=%0d empty=%b ovf=%b unf=%b valid=%b data=%h, required 0 1 0 0 0 2",
                  outCount, outEmpty, outOverflow, outUnderflow, outValid, outData);
      end
      drive(1'b0, 4'h0, 1'b1, 1'b0);
      total++;
      if (outUnderflow !== 1'b1 || outValid !== 1'b0 || outCount !== 4'd0) begin
         bad++;
         $display("FAIL clear_write_ignored: unf=%b valid=%b count=%0d, required 1 0 0", outUnderflow, outValid, outCount);
      end
      drive(1'b0, 4'h0, 1'b0, 1'b1);
   endtask

   task automatic test_async_reset;
      drive(1'b1, 4'h5, 1'b0, 1'b0);
      drive(1'b1, 4'h6, 1'b0, 1'b0);
      drive(1'b1, 4'h7, 1'b1, 1'b0);
      drive(1'b1, 4'h8, 1'b0, 1'b0);
      total++;
      if (outCount !== 4'd3 || outData !== 4'h5) begin
         bad++;
         $display("FAIL areset_pre: count=%0d data=%h, required 3 5", outCount, outData);
      end
      #2 inReset = 1'b0;
      #1;
      total++;
      if ({outCount, outEmpty, outAlmostEmpty, outFull, outAlmostFull, outValid, outOverflow, outUnderflow, outData} !== {4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0}) begin
         bad++;
         $display("FAIL areset_async: count=%0d empty=%b valid=%b data=%h, required 0 1 0 0", outCount, outEmpty, outValid, outData);
      end
      #2 inReset = 1'b1;
      drive(1'b0, 4'h0, 1'b1, 1'b0);
      total++;
      if (outUnderflow !== 1'b1 || outValid !== 1'b0 || outCount !== 4'd0) begin
         bad++;
         $display("FAIL areset_data_lost: unf=%b valid=%b count=%0d, required 1 0 0", outUnderflow, outValid, outCount);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_fill_overflow();
      test_underflow_write();
      test_full_rw();
      test_wrap();
      test_clear();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
